flash_cmd_engine: RTL



---
 rtl/flash_pkg.sv | 41 ++++
 rtl/flash_cmd_engine_spi_byte_shifter.sv | 68 ++++++
 rtl/flash_cmd_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared opcodes, internal command codes, engine states and length limits
// for the serial-flash command engine.
package flash_pkg;

   localparam logic [7:0] OP_RDID     = 8'h9F;
   localparam logic [7:0] OP_RDSR1    = 8'h05;
   localparam logic [7:0] OP_RDSR2    = 8'h07;
   localparam logic [7:0] OP_RES      = 8'hAB;
   localparam logic [7:0] OP_RDCR     = 8'h35;
   localparam logic [7:0] OP_FREAD    = 8'h0B;
   localparam logic [7:0] OP_PP       = 8'h02;
   localparam logic [7:0] OP_WREN     = 8'h06;
   localparam logic [7:0] OP_BE       = 8'hC7;

   localparam logic [7:0] CMD_PAGE_WR = 8'h11;

   localparam int MAX_TX = 10;
   localparam int MAX_RX = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_GAP,
      ST_FRAME,
      ST_POLL_GAP,
      ST_POLL,
      ST_DONE,
      ST_WAIT_REL
   } state_t;

   function automatic logic cmd_known(input logic [7:0] c);
      return c == OP_RDID || c == OP_RDSR1 || c == OP_RDSR2 || c == OP_RDCR ||
             c == OP_RES  || c == OP_FREAD || c == CMD_PAGE_WR || c == OP_BE;
   endfunction

   // Commands that modify the array need WREN first and WIP polling after.
   function automatic logic cmd_writes(input logic [7:0] c);
      return c == CMD_PAGE_WR || c == OP_BE;
   endfunction

endpackage

// File: rtl/flash_cmd_engine_spi_byte_shifter.sv
// Mode-0 SPI byte shifter: one MSB-first byte per start pulse, owns the SCK
// divider; SCK idles low and every byte ends on a falling edge.
module spi_byte_shifter #(
   parameter int CLK_DIV = 2
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic [7:0] rx_byte,
   output logic       done
);

   localparam int DW = $clog2(CLK_DIV + 1);

   logic          active;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    sh_tx;
   logic [7:0]    sh_rx;

   // Sample MISO as SCK rises; advance MOSI as SCK falls.
   always_ff @(posedge CLK) begin
      if (reset) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         sh_tx   <= '0;
         sh_rx   <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !active) begin
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh_tx   <= tx_byte;
            mosi    <= tx_byte[7];
            sclk    <= 1'b0;
         end else if (active) begin
            if (div_cnt == DW'(CLK_DIV - 1)) begin
               div_cnt <= '0;
               sclk    <= ~sclk;
               if (!sclk) begin
                  sh_rx <= {sh_rx[6:0], miso};
               end else if (bit_cnt == 3'd7) begin
                  active <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  sh_tx   <= {sh_tx[6:0], 1'b0};
                  mosi    <= sh_tx[6];
               end
            end else begin
               div_cnt <= div_cnt + DW'(1);
            end
         end
      end
   end

   assign rx_byte = sh_rx;

endmodule

// File: rtl/flash_cmd_engine.sv
// Serial-flash command engine: accepts one decoder request, runs the SPI
// frames (with WREN and WIP polling for writes) and returns up to 6 bytes.
module flash_cmd_engine
   import flash_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int CS_GAP      = 4,
   parameter int DUMMY_BYTES = 1
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [7:0]  MEMCMD,
   input  logic [23:0] MEMADDR,
   input  logic [47:0] MEMVAL,
   input  logic        MEMTRIG,
   input  logic        MEMQUAD,
   output logic        MEM_CTRL_busy,
   output logic [47:0] MEMDATA,
   output logic        mem_clk,
   output logic        oCS,
   output logic        SI_IO0,
   input  logic        SO_IO1,
   output logic        WP_IO2,
   output logic        HOLD_IO3
);

   localparam int GW    = $clog2(CS_GAP + 1);
   localparam int LEN_W = $clog2(MAX_TX + MAX_RX + 1);

   state_t        state, state_nxt;
   logic [7:0]    cmd_q;
   logic [23:0]   addr_q;
   logic [47:0]   val_q;
   logic [3:0]    byte_idx;
   logic [GW-1:0] gap_cnt;
   logic          start_q;
   logic          cs_n_q;
   logic [47:0]   rx_acc;
   logic [47:0]   memdata_q;

   logic [3:0]       tx_len, rx_len;
   logic [LEN_W-1:0] total_len;
   logic [7:0]       opcode, tx_byte;
   logic             frame_state, frame_end, last_byte, gap_done, entering_frame;
   logic             sh_done;
   logic [7:0]       sh_rx;
   logic             unused_quad;

   assign unused_quad = MEMQUAD;

   spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .CLK     (CLK),
      .reset   (reset),
      .start   (start_q),
      .tx_byte (tx_byte),
      .miso    (SO_IO1),
      .sclk    (mem_clk),
      .mosi    (SI_IO0),
      .rx_byte (sh_rx),
      .done    (sh_done)
   );

   // Frame shape for the current state: WREN and status polls are fixed.
   always_comb begin
      tx_len = 4'd1;
      rx_len = 4'd0;
      opcode = cmd_q;
      case (state)
         ST_WREN: opcode = OP_WREN;
         ST_POLL: begin
            opcode = OP_RDSR1;
            rx_len = 4'd1;
         end
         default: begin
            case (cmd_q)
               OP_RDID:                     rx_len = 4'd6;
               OP_RDSR1, OP_RDSR2, OP_RDCR: rx_len = 4'd1;
               OP_RES: begin
                  tx_len = 4'd4;
                  rx_len = 4'd1;
               end
               OP_FREAD: begin
                  tx_len = 4'(4 + DUMMY_BYTES);
                  rx_len = 4'd6;
               end
               CMD_PAGE_WR: begin
                  tx_len = 4'd10;
                  opcode = OP_PP;
               end
               default: ;
            endcase
         end
      endcase
   end

   // Byte on the wire: opcode, address, then payload or dummy/read zeros.
   always_comb begin
      tx_byte = 8'h00;
      if (byte_idx == 4'd0) begin
         tx_byte = opcode;
      end else if (state == ST_FRAME && cmd_q != OP_RES && byte_idx < tx_len) begin
         case (byte_idx)
            4'd1:    tx_byte = addr_q[23:16];
            4'd2:    tx_byte = addr_q[15:8];
            4'd3:    tx_byte = addr_q[7:0];
            4'd4:    tx_byte = (cmd_q == CMD_PAGE_WR) ? val_q[47:40] : 8'h00;
            4'd5:    tx_byte = (cmd_q == CMD_PAGE_WR) ? val_q[39:32] : 8'h00;
            4'd6:    tx_byte = (cmd_q == CMD_PAGE_WR) ? val_q[31:24] : 8'h00;
            4'd7:    tx_byte = (cmd_q == CMD_PAGE_WR) ? val_q[23:16] : 8'h00;
            4'd8:    tx_byte = (cmd_q == CMD_PAGE_WR) ? val_q[15:8]  : 8'h00;
            4'd9:    tx_byte = (cmd_q == CMD_PAGE_WR) ? val_q[7:0]   : 8'h00;
            default: tx_byte = 8'h00;
         endcase
      end
   end

   assign total_len   = LEN_W'(tx_len) + LEN_W'(rx_len);
   assign last_byte   = (LEN_W'(byte_idx) == total_len - LEN_W'(1));
   assign frame_state = (state == ST_WREN) || (state == ST_FRAME) || (state == ST_POLL);
   assign frame_end   = frame_state && sh_done && last_byte;
   assign gap_done    = (gap_cnt == GW'(CS_GAP - 1));

   always_ff @(posedge CLK) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (MEMTRIG) begin
               if (!cmd_known(MEMCMD))      state_nxt = ST_DONE;
               else if (cmd_writes(MEMCMD)) state_nxt = ST_WREN;
               else                         state_nxt = ST_FRAME;
            end
         ST_WREN:     if (frame_end) state_nxt = ST_GAP;
         ST_GAP:      if (gap_done)  state_nxt = ST_FRAME;
         ST_FRAME:
            if (frame_end) state_nxt = cmd_writes(cmd_q) ? ST_POLL_GAP : ST_DONE;
         ST_POLL_GAP: if (gap_done)  state_nxt = ST_POLL;
         ST_POLL:
            if (frame_end) state_nxt = sh_rx[0] ? ST_POLL_GAP : ST_DONE;
         ST_DONE:     state_nxt = ST_WAIT_REL;
         ST_WAIT_REL: if (!MEMTRIG) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   assign entering_frame = (state_nxt != state) &&
                           (state_nxt == ST_WREN || state_nxt == ST_FRAME || state_nxt == ST_POLL);

   // Request capture, chip select, byte sequencing and read accumulation.
   always_ff @(posedge CLK) begin
      if (reset) begin
         cmd_q     <= '0;
         addr_q    <= '0;
         val_q     <= '0;
         byte_idx  <= '0;
         gap_cnt   <= '0;
         start_q   <= 1'b0;
         cs_n_q    <= 1'b1;
         rx_acc    <= '0;
         memdata_q <= '0;
      end else begin
         start_q <= 1'b0;
         if (state == ST_IDLE && MEMTRIG) begin
            cmd_q  <= MEMCMD;
            addr_q <= MEMADDR;
            val_q  <= MEMVAL;
         end
         if (entering_frame) begin
            cs_n_q   <= 1'b0;
            start_q  <= 1'b1;
            byte_idx <= '0;
            rx_acc   <= '0;
         end else if (frame_state && sh_done) begin
            if (byte_idx >= tx_len) rx_acc <= {rx_acc[39:0], sh_rx};
            if (last_byte) begin
               cs_n_q <= 1'b1;
            end else begin
               byte_idx <= byte_idx + 4'd1;
               start_q  <= 1'b1;
            end
         end
         gap_cnt <= (state == ST_GAP || state == ST_POLL_GAP) ? gap_cnt + GW'(1) : '0;
         if (state == ST_DONE && cmd_known(cmd_q)) memdata_q <= rx_acc;
      end
   end

   assign MEM_CTRL_busy = (state != ST_IDLE) && (state != ST_WAIT_REL);
   assign MEMDATA       = memdata_q;
   assign oCS           = cs_n_q;
   assign WP_IO2        = 1'b1;
   assign HOLD_IO3      = 1'b1;

endmodule
